// File: rtl/eth_rx_frame_buf_if.sv
// Byte-stream bundle between the receive parser, the frame buffer and the downstream consumer.
// The buffer takes the slave view; the parser/consumer side takes the master view.
interface eth_rx_frame_buf_if;
  logic       in_byte_vld;
  logic [7:0] in_byte;
  logic       in_eof;
  logic       in_frame_ok;

  logic       out_byte_vld;
  logic       out_byte_rdy;
  logic [7:0] out_byte;
  logic       out_last;

  modport slave (
    input  in_byte_vld, in_byte, in_eof, in_frame_ok, out_byte_rdy,
    output out_byte_vld, out_byte, out_last
  );

  modport master (
    output in_byte_vld, in_byte, in_eof, in_frame_ok, out_byte_rdy,
    input  out_byte_vld, out_byte, out_last
  );
endinterface

// File: rtl/eth_rx_frame_buf.sv
// Store-and-forward receive frame buffer: holds each frame until its status is known,
// forwards good frames on a ready/valid byte stream and rolls back bad or overflowing ones.
module eth_rx_frame_buf #(
  parameter int P_DEPTH    = 2048,
  parameter int P_CNT_BITS = 16
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  eth_rx_frame_buf_if.slave     bus,
  output logic                  drop_pulse,
  output logic [P_CNT_BITS-1:0] drop_cnt
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]         FULL_OCC = PW'(P_DEPTH);
  localparam logic [P_CNT_BITS-1:0] CNT_ONE  = P_CNT_BITS'(1);

  typedef enum logic {
    S_ACCEPT,
    S_DROP
  } wr_state_e;

  // Each entry is {eof, byte}.
  logic [8:0] mem [P_DEPTH];

  wr_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  drop_q, drop_d;
  logic [P_CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;
  logic                  out_vld_q, out_vld_d;
  logic [8:0]            out_data_q, out_data_d;

  logic [PW-1:0] occupancy;
  logic          full;
  logic          mem_we;
  logic          rd_load;

  // The MSB wrap bit makes wr - rd exact even when both pointers have lapped the array.
  // Registered rd_ptr is used, so a same-cycle read never frees space for this write.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == FULL_OCC);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    drop_d       = 1'b0;

    unique case (state_q)
      S_ACCEPT: begin
        if (bus.in_byte_vld) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (bus.in_eof) begin
              if (bus.in_frame_ok) begin
                commit_ptr_d = wr_ptr_q + PTR_ONE;
              end else begin
                wr_ptr_d = commit_ptr_q;
                drop_d   = 1'b1;
              end
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            if (bus.in_eof) begin
              drop_d = 1'b1;
            end else begin
              state_d = S_DROP;
            end
          end
        end
      end

      S_DROP: begin
        if (bus.in_byte_vld && bus.in_eof) begin
          drop_d  = 1'b1;
          state_d = S_ACCEPT;
        end
      end

      default: state_d = S_ACCEPT;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  // Only committed entries are ever read, so a read never races the write of the same slot.
  assign rd_load = (rd_ptr_q != commit_ptr_q) && (!out_vld_q || bus.out_byte_rdy);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (rd_load) begin
      out_data_d = mem[rd_ptr_q[AW-1:0]];
      out_vld_d  = 1'b1;
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end else if (bus.out_byte_rdy) begin
      out_vld_d  = 1'b0;
    end
  end

  // NOTE: the storage array has no reset; pointers define what is valid, and leaving it
  // out of the reset network lets it map onto RAM.
  always_ff @(posedge rx_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {bus.in_eof, bus.in_byte};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q      <= S_ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 1'b0;
      drop_cnt_q   <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
      drop_cnt_q   <= drop_cnt_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.out_byte_vld = out_vld_q;
  assign bus.out_last     = out_data_q[8];
  assign bus.out_byte     = out_data_q[7:0];
  assign drop_pulse       = drop_q;
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: doc/eth_rx_frame_buf.md
# eth_rx_frame_buf

Store-and-forward frame buffer directly downstream of the Ethernet receive frame parser in the `rx_clk` domain. It accepts the parser's unthrottled byte stream, holds each frame until its end-of-frame status is known, and commits good frames to a ready/valid byte output carrying a `last` flag. Bad frames and frames that overflow the buffer are rolled back and never appear on the output.

## Interface
- `P_DEPTH`, 2048: buffer depth in bytes; power of two, ≥ 4; 2048 holds one maximum 1518-byte frame.
- `P_CNT_BITS`, 16: width of the drop counter.

One clock; reset is asynchronous and active-low.
- `rx_clk`  in  1  receive clock; all logic is on its rising edge.
- `rx_rst_n`  in  1  asynchronous, active-low reset.
- `in_byte_vld`  in  1  input byte strobe; no backpressure toward the parser.
- `in_byte`  in  8  input byte.
- `in_eof`  in  1  marks the last byte of a frame; sampled only when `in_byte_vld`=1.
- `in_frame_ok`  in  1  frame status (FCS/length good); sampled only with `in_eof`.
- `out_byte_vld`  out  1  output byte valid.
- `out_byte_rdy`  in  1  downstream ready.
- `out_byte`  out  8  output byte.
- `out_last`  out  1  output byte is the last byte of its frame.
- `drop_pulse`  out  1  one-cycle pulse per discarded frame.
- `drop_cnt`  out  P_CNT_BITS  discarded-frame count; saturates at all-ones.

## Operation
- Storage: `P_DEPTH` entries × 9 bits ({eof, byte}).
- Pointers: `wr_ptr`, `commit_ptr`, `rd_ptr`, each log2(P_DEPTH)+1 bits, with an MSB wrap bit. Occupancy is `wr_ptr − rd_ptr` (modulo). Full means occupancy = `P_DEPTH`.
- Write FSM, two states:
  - **ACCEPT**:
    - On `in_byte_vld` when not full, write `{in_eof, in_byte}` at `wr_ptr` and increment `wr_ptr`.
    - If that beat has `in_eof`=1 and `in_frame_ok`=1, set `commit_ptr` to the incremented `wr_ptr`.
    - If that beat has `in_eof`=1 and `in_frame_ok`=0, roll back: `wr_ptr` ← `commit_ptr`, and pulse `drop_pulse`.
    - On `in_byte_vld` when full: roll back `wr_ptr` ← `commit_ptr`.
      - If the beat also has `in_eof`=1, pulse `drop_pulse` and stay in ACCEPT.
      - Otherwise go to DROP.
  - **DROP**: ignore bytes. On an `in_byte_vld` beat with `in_eof`=1, pulse `drop_pulse` and go to ACCEPT.
- `drop_cnt` increments on every `drop_pulse` and saturates.
- The full test uses registered `rd_ptr`. A read in the same cycle does not free space for that write (conservative).
- Read side:
  - A single output register holds {`out_last`, `out_byte`} and `out_byte_vld`.
  - The register loads `mem[rd_ptr]` and increments `rd_ptr` when `rd_ptr` ≠ `commit_ptr` and (`out_byte_vld`=0 or `out_byte_rdy`=1).
  - Otherwise `out_byte_vld` clears on `out_byte_rdy`.
- Uncommitted bytes are never read. Output frames are complete, in order, and byte-exact.

## Timing
- Reset values:
  - `out_byte_vld`=0, `out_byte`=0, `out_last`=0.
  - `drop_pulse`=0, `drop_cnt`=0.
  - All pointers 0; FSM in ACCEPT.
- Memory contents are not reset.
- Latency: if the eof beat is sampled at edge E0, `commit_ptr` updates at E0. The first byte is valid after E1 (one cycle after the eof cycle).
  - This holds only if the output register is empty. If it is busy, the first byte loads on the next allowed load.
- Throughput: one byte per cycle in and out, concurrently.
- Handshake:
  - A transfer occurs when `out_byte_vld`=1 and `out_byte_rdy`=1.
  - `out_byte`/`out_last` are held stable while `out_byte_vld`=1 and `out_byte_rdy`=0.
  - `out_byte_vld` never drops without a transfer.
- `drop_pulse` is registered; it is high the cycle after the dropping beat.
- Boundary conditions:
  - A frame of exactly `P_DEPTH` bytes into an empty buffer is accepted.
  - A frame of `P_DEPTH`+1 bytes is dropped.
  - Pointer wrap is handled by the MSB; no reset of pointers between frames.
  - Single-byte frames (first beat has `in_eof`) are legal.
  - Reset mid-frame or mid-output discards all contents. The parser shares `rx_rst_n`, so no partial frame follows reset.

## Test plan
- **Good frame:** 64-byte good frame, `out_byte_rdy`=1 → 64 bytes out in order, `out_last` only on byte 64, first `out_byte_vld` one cycle after the eof cycle, `drop_cnt`=0.
- **Bad frame:** 20-byte frame with `in_frame_ok`=0, then a 30-byte good frame → only the 30 bytes are output, `drop_pulse` high for one cycle, `drop_cnt`=1.
- **Overflow:** `P_DEPTH`=16, `out_byte_rdy`=0, 10-byte good frame then 10-byte good frame → second frame dropped (`drop_cnt`=1). On releasing rdy, exactly the first 10 bytes are output with `last` on byte 10, then `out_byte_vld`=0.
- **Exact fit:** `P_DEPTH`=16, empty buffer, rdy=0: 16-byte frame → accepted and fully output. 17-byte frame → dropped, nothing output, FSM back in ACCEPT.
- **Backpressure:** random `out_byte_rdy` (50%), back-to-back frames of 1, 60, 1518 and 1 bytes (`P_DEPTH`=2048) → scoreboard byte-exact with correct `last`, no data change while stalled, no drops.
- **Reset mid-output:** assert `rx_rst_n`=0 during output of a frame → `out_byte_vld`=0 and `drop_cnt`=0 immediately. A subsequent 8-byte good frame outputs correctly.
